uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver: the next generation of the team's fixed 8N1 receiver. It adds configurable frame format, mid-bit sampling from an oversampled tick, false-start rejection, parity and framing error detection, and a valid/ready output holding register with overrun flag. It sits between the pad-side serial input and the byte-consuming logic (FIFO or register bank), driven by a shared baud-tick generator running at OVERSAMPLE × baud.

---
 rtl/uart_rx_os_if.sv | 28 ++
 rtl/uart_rx_os.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Receive-side handshake bundle between uart_rx_os and the byte consumer.
//   o_rx_data     : received data word, LSB = first bit on the line
//   o_rx_valid    : a held frame is available
//   o_parity_err  : parity mismatch on the held frame
//   o_frame_err   : stop bit(s) sampled low on the held frame
//   o_overrun     : one-clk pulse, a completed frame was dropped
//   i_rx_ready    : consumer accepts the held frame
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] o_rx_data;
   logic                 o_rx_valid;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_overrun;
   logic                 i_rx_ready;

   modport master (
      output o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_overrun,
      input  i_rx_ready
   );

   modport slave (
      input  o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_overrun,
      output i_rx_ready
   );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable frame format, false-start
// rejection, parity/framing error detection and a valid/ready holding register.
//   clk, reset : clock, synchronous active-high reset
//   i_tick     : one-clk enable at OVERSAMPLE x baud
//   i_rxd      : asynchronous serial line, idle high
//   rx         : uart_rx_os_if master (data, valid, error flags, overrun, ready)
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority bit decision around the
// sample point instead of a single sample.
module uart_rx_os #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_tick,
   input  logic         i_rxd,
   uart_rx_os_if.master rx
);
   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam int unsigned SP    = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned DEC   = SP + 1;
`else
   localparam int unsigned DEC   = SP;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_e;

   state_e               state_q, state_d;
   logic                 rxd_meta_q, rxd_s_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_acc_q, par_acc_d;
   logic                 frm_acc_q, frm_acc_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   logic decide_c, bit_c, bit_end_c, last_data_c, last_stop_c, complete_c;

   // Two-flop synchroniser, resets to the idle level
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= i_rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Samples at SP-1 and SP; the vote is taken at SP+1 with the live sample
   logic samp_a_q, samp_a_d, samp_b_q, samp_b_d;

   always_comb begin
      samp_a_d = samp_a_q;
      samp_b_d = samp_b_q;
      if (i_tick && cnt_q == CNT_W'(SP - 1)) samp_a_d = rxd_s_q;
      if (i_tick && cnt_q == CNT_W'(SP))     samp_b_d = rxd_s_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         samp_a_q <= 1'b1;
         samp_b_q <= 1'b1;
      end else begin
         samp_a_q <= samp_a_d;
         samp_b_q <= samp_b_d;
      end
   end

   assign bit_c = (samp_a_q & samp_b_q) | (samp_a_q & rxd_s_q) | (samp_b_q & rxd_s_q);
`else
   assign bit_c = rxd_s_q;
`endif

   assign decide_c    = i_tick && (cnt_q == CNT_W'(DEC));
   assign bit_end_c   = i_tick && (cnt_q == CNT_W'(OVERSAMPLE - 1));
   assign last_data_c = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
   assign last_stop_c = (stop_cnt_q == 1'(STOP_BITS - 1));
   // Frame completes at the decision of the last stop bit, not at its end
   assign complete_c  = (state_q == S_STOP) && decide_c && last_stop_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (i_tick && !rxd_s_q) state_d = S_START;
         S_START: begin
            if (decide_c && bit_c) state_d = S_IDLE;   // false start
            else if (bit_end_c)    state_d = S_DATA;
         end
         S_DATA:      if (bit_end_c && last_data_c)
                         state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY:    if (bit_end_c) state_d = S_STOP;
         S_STOP:      if (complete_c)
                         state_d = (frm_acc_q || !bit_c) ? S_WAIT_HIGH : S_IDLE;
         S_WAIT_HIGH: if (i_tick && rxd_s_q) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Counters, shift register, error accumulation and holding register
   always_comb begin
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shift_d      = shift_q;
      par_acc_d    = par_acc_q;
      frm_acc_d    = frm_acc_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = 1'b0;

      if (state_q == S_IDLE || state_q == S_WAIT_HIGH) begin
         cnt_d      = '0;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
         par_acc_d  = 1'b0;
         frm_acc_d  = 1'b0;
      end else if (i_tick) begin
         cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_DATA: begin
            if (decide_c)  shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
            if (bit_end_c) bit_cnt_d = last_data_c ? '0 : bit_cnt_q + BIT_W'(1);
         end
         S_PARITY: begin
            // Odd: data ^ parity must be 1; even: must be 0
            if (decide_c)
               par_acc_d = (PARITY == 1) ? ~(^shift_q ^ bit_c) : (^shift_q ^ bit_c);
         end
         S_STOP: begin
            if (decide_c && !bit_c) frm_acc_d = 1'b1;
            if (bit_end_c)          stop_cnt_d = 1'b1;
         end
         default: ;
      endcase

      if (complete_c) begin
         if (!rx_valid_q || rx.i_rx_ready) begin
            rx_data_d    = shift_q;
            parity_err_d = par_acc_q;
            frame_err_d  = frm_acc_q | ~bit_c;
            rx_valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx.i_rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         shift_q      <= '0;
         par_acc_q    <= 1'b0;
         frm_acc_q    <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         shift_q      <= shift_d;
         par_acc_q    <= par_acc_d;
         frm_acc_q    <= frm_acc_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx.o_rx_data    = rx_data_q;
   assign rx.o_rx_valid   = rx_valid_q;
   assign rx.o_parity_err = parity_err_q;
   assign rx.o_frame_err  = frame_err_q;
   assign rx.o_overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os in 8E1, OVERSAMPLE=16, tick every clk.
// Stimulus pushes expected frames; the monitor pops on each valid&ready.
module tb_uart_rx_os;
   localparam int unsigned OS = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int DEC = OS / 2 + 1;
`else
   localparam int DEC = OS / 2;
`endif
   // Line-clock index whose following posedge completes an 8E1 frame
   localparam int COMPL = 3 + 10 * OS + DEC;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic i_tick;
   logic i_rxd;

   exp_t exp_q[$];
   int   checks       = 0;
   int   failures     = 0;
   int   overrun_seen = 0;

   uart_rx_os_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_os #(
      .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .i_tick (i_tick),
      .i_rxd  (i_rxd),
      .rx     (rx_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      return e;
   endfunction

   task automatic line(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         i_rxd = v;
      end
   endtask

   // One 8E1 frame; stop_low extends a low line for that many bit times,
   // glitch_at forces one line clock low, ready_at raises i_rx_ready.
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input int stop_low,
                             input int glitch_at, input int ready_at);
      logic [7:0] dd;
      int         nbits;
      int         b;
      logic       v;
      dd    = d;
      nbits = 11 + stop_low;
      for (int j = 0; j < nbits * OS; j++) begin
         b = j / OS;
         if (b == 0)               v = 1'b0;
         else if (b <= 8)          v = dd[b-1];
         else if (b == 9)          v = (^dd) ^ par_flip;
         else if (b < 10 + stop_low) v = 1'b0;
         else                      v = 1'b1;
         if (j == glitch_at) v = ~v;
         @(negedge clk);
         i_rxd = v;
         if (j == ready_at) rx_if.i_rx_ready = 1'b1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: samples after inputs settle, before the next posedge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && rx_if.o_rx_valid && rx_if.i_rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame: got data 0x%0h pe %0b fe %0b, expected no frame",
                        rx_if.o_rx_data, rx_if.o_parity_err, rx_if.o_frame_err);
            end else begin
               e = exp_q.pop_front();
               chk("rx_data", 32'(rx_if.o_rx_data), 32'(e.d));
               chk("parity_err", 32'(rx_if.o_parity_err), 32'(e.pe));
               chk("frame_err", 32'(rx_if.o_frame_err), 32'(e.fe));
            end
         end
         if (!reset && rx_if.o_overrun) overrun_seen++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      i_tick = 1'b1;
      i_rxd = 1'b1;
      rx_if.i_rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_data", 32'(rx_if.o_rx_data), 32'd0);
      chk("rst_valid", 32'(rx_if.o_rx_valid), 32'd0);
      chk("rst_pe", 32'(rx_if.o_parity_err), 32'd0);
      chk("rst_fe", 32'(rx_if.o_frame_err), 32'd0);
      chk("rst_ovr", 32'(rx_if.o_overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      rx_if.i_rx_ready = 1'b1;
      line(1'b1, 2 * OS);

      // Clean frame and parity error
      exp_q.push_back(mk(8'hA5, 1'b0, 1'b0));
      send_frame(8'hA5, 1'b0, 0, -1, -1);
      line(1'b1, OS);
      drain("drain_a5");
      #1 chk("valid_one_clk_a5", 32'(rx_if.o_rx_valid), 32'd0);
      exp_q.push_back(mk(8'h3C, 1'b1, 1'b0));
      send_frame(8'h3C, 1'b1, 0, -1, -1);
      line(1'b1, OS);
      drain("drain_3c");

      // Break: stop low three bit times, then a clean frame
      exp_q.push_back(mk(8'h00, 1'b0, 1'b1));
      send_frame(8'h00, 1'b0, 3, -1, -1);
      line(1'b1, 2 * OS);
      drain("drain_break");
      exp_q.push_back(mk(8'hC3, 1'b0, 1'b0));
      send_frame(8'hC3, 1'b0, 0, -1, -1);
      line(1'b1, OS);
      drain("drain_c3");

      // Short low glitch on idle line is rejected
      line(1'b0, 2);
      line(1'b1, 4 * OS);
      #1 chk("glitch_no_valid", 32'(rx_if.o_rx_valid), 32'd0);
`ifdef UART_RX_MAJORITY_EN
      exp_q.push_back(mk(8'h55, 1'b0, 1'b0));
      send_frame(8'h55, 1'b0, 0, OS + OS / 2 + 1, -1);
      line(1'b1, OS);
      drain("drain_55_majority");
`endif

      // Overrun: second frame dropped while first is held
      rx_if.i_rx_ready = 1'b0;
      exp_q.push_back(mk(8'h11, 1'b0, 1'b0));
      send_frame(8'h11, 1'b0, 0, -1, -1);
      line(1'b1, OS);
      send_frame(8'h22, 1'b0, 0, -1, -1);
      line(1'b1, OS);
      #1;
      chk("overrun_count", 32'(overrun_seen), 32'd1);
      chk("held_data_11", 32'(rx_if.o_rx_data), 32'h11);
      chk("held_valid_11", 32'(rx_if.o_rx_valid), 32'd1);
      rx_if.i_rx_ready = 1'b1;
      drain("drain_11");

      // Ready on the completion clk: old frame accepted, new frame loaded
      @(negedge clk);
      rx_if.i_rx_ready = 1'b0;
      exp_q.push_back(mk(8'h33, 1'b0, 1'b0));
      send_frame(8'h33, 1'b0, 0, -1, -1);
      line(1'b1, OS);
      exp_q.push_back(mk(8'h44, 1'b0, 1'b0));
      send_frame(8'h44, 1'b0, 0, -1, COMPL);
      line(1'b1, OS);
      drain("drain_33_44");
      chk("no_overrun_on_accept", 32'(overrun_seen), 32'd1);

      // Reset mid-frame with a held errored frame
      rx_if.i_rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, 0, -1, -1);
      line(1'b1, OS);
      #1;
      chk("pre_rst_valid", 32'(rx_if.o_rx_valid), 32'd1);
      chk("pre_rst_data", 32'(rx_if.o_rx_data), 32'h5A);
      chk("pre_rst_pe", 32'(rx_if.o_parity_err), 32'd1);
      for (int j = 0; j < 5 * OS + 8; j++) begin
         @(negedge clk);
         i_rxd = (j < OS) ? 1'b0 : ((8'h77 >> (j / OS - 1)) & 8'h01) != 8'h00;
      end
      @(negedge clk);
      reset = 1'b1;
      i_rxd = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_data", 32'(rx_if.o_rx_data), 32'd0);
      chk("mid_rst_valid", 32'(rx_if.o_rx_valid), 32'd0);
      chk("mid_rst_pe", 32'(rx_if.o_parity_err), 32'd0);
      chk("mid_rst_fe", 32'(rx_if.o_frame_err), 32'd0);
      chk("mid_rst_ovr", 32'(rx_if.o_overrun), 32'd0);
      rx_if.i_rx_ready = 1'b1;
      line(1'b1, 2 * OS);
      exp_q.push_back(mk(8'h96, 1'b0, 1'b0));
      send_frame(8'h96, 1'b0, 0, -1, -1);
      line(1'b1, OS);
      drain("drain_96");

      line(1'b1, 2 * OS);
      chk("final_overrun_count", 32'(overrun_seen), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
